// File: rtl/uart_rx_param.sv
// -----------------------------------------------------------------------------
// uart_rx_param
//
// Parametrised UART receiver. The serial line is oversampled using an external
// baud-tick enable (i_tick, N_OVERSAMPLE pulses per bit period). The receiver
// handles 5..9 data bits (LSB first), an optional even/odd parity bit and one
// or two stop bits. Every received word is delivered together with its parity
// and framing error flags, even when one of the flags is set.
//
// Parameters:
//   NB_DATA      data bits per frame (5..9)
//   N_OVERSAMPLE i_tick pulses per bit period (even, >= 4)
//   PARITY_EN    1 = a parity bit follows the data bits
//   PARITY_ODD   0 = even parity, 1 = odd parity (ignored if PARITY_EN = 0)
//   NB_STOP      number of stop bits (1 or 2)
//
// Ports:
//   i_clk         system clock
//   i_rst         synchronous, active-high reset
//   i_tick        oversample enable from the baud generator, 1-cycle pulse
//   i_rx          asynchronous serial input, idle high
//   o_data        last received word (LSB = first data bit on the line)
//   o_rx_done     1-cycle pulse: o_data and the error flags are new
//   o_parity_err  parity mismatch on the last word
//   o_frame_err   a stop bit was sampled low on the last word
//   o_busy        high while the receiver is not idle
//   o_state       current FSM state, for debug and checker binding
//
// Handshake: o_rx_done is a pure valid strobe with no ready. o_data,
// o_parity_err and o_frame_err are valid in the cycle o_rx_done is high and
// hold their value until the next o_rx_done; the consumer must take the word
// in that cycle or read the held value before the next frame completes.
// -----------------------------------------------------------------------------
module uart_rx_param #(
  parameter int NB_DATA      = 8,
  parameter int N_OVERSAMPLE = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int NB_STOP      = 1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_tick,
  input  logic               i_rx,
  output logic [NB_DATA-1:0] o_data,
  output logic               o_rx_done,
  output logic               o_parity_err,
  output logic               o_frame_err,
  output logic               o_busy,
  output logic [2:0]         o_state
);

  localparam int TW = $clog2(N_OVERSAMPLE);
  localparam int BW = $clog2(NB_DATA + 1);

  // Tick count at which the start bit is at its midpoint, and the tick count
  // one full bit period later (which therefore lands on every later midpoint).
  localparam logic [TW-1:0] TICK_MID = TW'(N_OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_END = TW'(N_OVERSAMPLE - 1);

  localparam logic [BW-1:0] LAST_DATA = BW'(NB_DATA - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(NB_STOP - 1);

  localparam logic          PAR_ODD_BIT = (PARITY_ODD != 0);
  localparam bit            HAS_PARITY  = (PARITY_EN != 0);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]         state;
  logic               rx_meta;
  logic               rx_s;
  logic               armed;
  logic [TW-1:0]      tick_cnt;
  logic [BW-1:0]      bit_cnt;
  logic [NB_DATA-1:0] shift_r;
  logic               par_err_r;
  logic               frame_err_r;

  // Sampling point inside the DATA/PARITY/STOP bit periods.
  logic at_bit_mid;
  assign at_bit_mid = i_tick && (tick_cnt == TICK_END);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= S_IDLE;
      rx_meta      <= 1'b1;
      rx_s         <= 1'b1;
      armed        <= 1'b1;
      tick_cnt     <= '0;
      bit_cnt      <= '0;
      shift_r      <= '0;
      par_err_r    <= 1'b0;
      frame_err_r  <= 1'b0;
      o_data       <= '0;
      o_rx_done    <= 1'b0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
    end else begin
      // Two-flop synchroniser; nothing below looks at i_rx directly.
      rx_meta   <= i_rx;
      rx_s      <= rx_meta;
      o_rx_done <= 1'b0;

      case (state)
        S_IDLE: begin
          // armed only re-asserts once the line has been seen high, so a
          // line held low (break) after a framing error cannot start frames.
          if (rx_s) begin
            armed <= 1'b1;
          end else if (armed) begin
            state    <= S_START;
            tick_cnt <= '0;
            armed    <= 1'b0;
          end
        end

        S_START: begin
          if (i_tick) begin
            if (tick_cnt == TICK_MID) begin
              if (!rx_s) begin
                state       <= S_DATA;
                tick_cnt    <= '0;
                bit_cnt     <= '0;
                par_err_r   <= 1'b0;
                frame_err_r <= 1'b0;
              end else begin
                // Line went back high before the midpoint: a glitch, not a
                // start bit. Leave every output untouched.
                state <= S_IDLE;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end

        S_DATA: begin
          if (at_bit_mid) begin
            // LSB arrives first, so shifting right with the new bit entering
            // at the MSB leaves the first bit in bit 0 after NB_DATA samples.
            shift_r  <= {rx_s, shift_r[NB_DATA-1:1]};
            tick_cnt <= '0;
            if (bit_cnt == LAST_DATA) begin
              bit_cnt <= '0;
              state   <= HAS_PARITY ? S_PARITY : S_STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else if (i_tick) begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end

        S_PARITY: begin
          if (at_bit_mid) begin
            // Data bits plus parity bit XOR to 0 for even, 1 for odd parity.
            par_err_r <= ((^shift_r) ^ rx_s) != PAR_ODD_BIT;
            tick_cnt  <= '0;
            state     <= S_STOP;
          end else if (i_tick) begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end

        S_STOP: begin
          if (at_bit_mid) begin
            tick_cnt <= '0;
            if (bit_cnt == LAST_STOP) begin
              // Final stop sample: publish the word and flags in one go. The
              // current sample is folded straight into the published flag.
              bit_cnt      <= '0;
              state        <= S_IDLE;
              o_data       <= shift_r;
              o_parity_err <= par_err_r;
              o_frame_err  <= frame_err_r | ~rx_s;
              o_rx_done    <= 1'b1;
            end else begin
              bit_cnt     <= bit_cnt + 1'b1;
              frame_err_r <= frame_err_r | ~rx_s;
            end
          end else if (i_tick) begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_busy  = (state != S_IDLE);
  assign o_state = state;

endmodule

// File: tb/tb_uart_rx_param.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_param
//
// Bench for uart_rx_param. Four receivers with different frame formats share
// clock, reset and baud tick; each has its own serial line:
//   u_8n1 : 8 data, no parity, 1 stop
//   u_8e1 : 8 data, even parity, 1 stop
//   u_8o1 : 8 data, odd parity, 1 stop
//   u_7n2 : 7 data, no parity, 2 stops
// A frame generator drives a line at 4 clk per tick, 16 ticks per bit, and a
// reference model derives the expected word and flags from the frame it sent.
// -----------------------------------------------------------------------------
module tb_uart_rx_param;

  localparam int BIT_CLK = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       rx [4];

  logic [7:0] d0, d1, d2;
  logic [6:0] d3;
  logic [3:0] done, pe, fe, busy;
  logic [2:0] st0, st1, st2, st3;

  int         tests = 0;
  int         failed = 0;
  int         width_err = 0;
  logic [3:0] done_prev = '0;

  // Record layout: {instance[1:0], parity_err, frame_err, data[8:0]}
  logic [12:0] cap_q[$];
  logic [12:0] exp_q[$];

  // ---------------------------------------------------------------- clock/reset
  always #5 clk = ~clk;

  initial begin
    forever begin
      repeat (3) @(negedge clk);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "bench timed out");
  end

  // ---------------------------------------------------------------- DUTs
  uart_rx_param #(.NB_DATA(8), .N_OVERSAMPLE(16), .PARITY_EN(0), .PARITY_ODD(0), .NB_STOP(1)) u_8n1 (
    .i_clk(clk), .i_rst(rst), .i_tick(tick), .i_rx(rx[0]),
    .o_data(d0), .o_rx_done(done[0]), .o_parity_err(pe[0]), .o_frame_err(fe[0]),
    .o_busy(busy[0]), .o_state(st0));

  uart_rx_param #(.NB_DATA(8), .N_OVERSAMPLE(16), .PARITY_EN(1), .PARITY_ODD(0), .NB_STOP(1)) u_8e1 (
    .i_clk(clk), .i_rst(rst), .i_tick(tick), .i_rx(rx[1]),
    .o_data(d1), .o_rx_done(done[1]), .o_parity_err(pe[1]), .o_frame_err(fe[1]),
    .o_busy(busy[1]), .o_state(st1));

  uart_rx_param #(.NB_DATA(8), .N_OVERSAMPLE(16), .PARITY_EN(1), .PARITY_ODD(1), .NB_STOP(1)) u_8o1 (
    .i_clk(clk), .i_rst(rst), .i_tick(tick), .i_rx(rx[2]),
    .o_data(d2), .o_rx_done(done[2]), .o_parity_err(pe[2]), .o_frame_err(fe[2]),
    .o_busy(busy[2]), .o_state(st2));

  uart_rx_param #(.NB_DATA(7), .N_OVERSAMPLE(16), .PARITY_EN(0), .PARITY_ODD(0), .NB_STOP(2)) u_7n2 (
    .i_clk(clk), .i_rst(rst), .i_tick(tick), .i_rx(rx[3]),
    .o_data(d3), .o_rx_done(done[3]), .o_parity_err(pe[3]), .o_frame_err(fe[3]),
    .o_busy(busy[3]), .o_state(st3));

  // ---------------------------------------------------------------- monitor
  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (done[k] && done_prev[k]) width_err++;
    end
    if (done[0]) cap_q.push_back({2'd0, pe[0], fe[0], 1'b0, d0});
    if (done[1]) cap_q.push_back({2'd1, pe[1], fe[1], 1'b0, d1});
    if (done[2]) cap_q.push_back({2'd2, pe[2], fe[2], 1'b0, d2});
    if (done[3]) cap_q.push_back({2'd3, pe[3], fe[3], 2'b00, d3});
    done_prev = done;
  end

  // ---------------------------------------------------------------- helpers
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input int k, input logic b);
    rx[k] = b;
    repeat (BIT_CLK) @(negedge clk);
  endtask

  task automatic idle_bits(input int k, input int n);
    for (int i = 0; i < n; i++) drive_bit(k, 1'b1);
  endtask

  // Drive one frame and record what a correct receiver must report for it.
  task automatic send_frame(input int k, input logic [8:0] data, input int nb,
                            input bit par_en, input bit par_odd, input logic pbit,
                            input int nstop, input logic [1:0] stops);
    logic [8:0] mdata;
    logic       perr;
    logic       ferr;
    drive_bit(k, 1'b0);
    for (int i = 0; i < nb; i++) drive_bit(k, data[i]);
    if (par_en) drive_bit(k, pbit);
    for (int s = 0; s < nstop; s++) drive_bit(k, stops[s]);
    mdata = data & 9'((1 << nb) - 1);
    perr  = par_en ? ((($countones(mdata) + int'(pbit)) % 2) != int'(par_odd)) : 1'b0;
    ferr  = (stops[0] == 1'b0) || (nstop == 2 && stops[1] == 1'b0);
    exp_q.push_back({2'(k), perr, ferr, mdata});
  endtask

  task automatic check_frames(input string tag);
    logic [12:0] c;
    logic [12:0] e;
    chk({tag, "_count"}, cap_q.size(), exp_q.size());
    while (cap_q.size() > 0 && exp_q.size() > 0) begin
      c = cap_q.pop_front();
      e = exp_q.pop_front();
      chk({tag, "_inst"}, 32'(c[12:11]), 32'(e[12:11]));
      chk({tag, "_data"}, 32'(c[8:0]), 32'(e[8:0]));
      chk({tag, "_perr"}, 32'(c[10]), 32'(e[10]));
      chk({tag, "_ferr"}, 32'(c[9]), 32'(e[9]));
    end
    cap_q.delete();
    exp_q.delete();
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    logic [8:0] rdata;
    logic [1:0] rstops;
    logic       rpbit;
    int         nb;
    int         nstop;
    bit         par_en;
    bit         par_odd;

    for (int k = 0; k < 4; k++) rx[k] = 1'b1;
    rst = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_data0", 32'(d0), 0);
    chk("reset_data3", 32'(d3), 0);
    chk("reset_done", 32'(done), 0);
    chk("reset_perr", 32'(pe), 0);
    chk("reset_ferr", 32'(fe), 0);
    chk("reset_busy", 32'(busy), 0);

    // 8N1 word 0xA5
    send_frame(0, 9'h0A5, 8, 0, 0, 1'b0, 1, 2'b11);
    idle_bits(0, 2);
    check_frames("t1");
    chk("t1_busy_after", 32'(busy[0]), 0);

    // Glitch of 4 ticks on the line: no frame, word held
    rx[0] = 1'b0;
    repeat (16) @(negedge clk);
    rx[0] = 1'b1;
    idle_bits(0, 2);
    chk("t2_no_frame", cap_q.size(), 0);
    chk("t2_data_held", 32'(d0), 32'h0A5);
    chk("t2_busy", 32'(busy[0]), 0);
    send_frame(0, 9'h05A, 8, 0, 0, 1'b0, 1, 2'b11);
    idle_bits(0, 2);
    check_frames("t2");

    // Parity, even and odd, with both parity-bit values
    send_frame(1, 9'h037, 8, 1, 0, 1'b1, 1, 2'b11);
    idle_bits(1, 1);
    send_frame(1, 9'h037, 8, 1, 0, 1'b0, 1, 2'b11);
    idle_bits(1, 1);
    check_frames("t3_even");
    send_frame(2, 9'h037, 8, 1, 1, 1'b1, 1, 2'b11);
    idle_bits(2, 1);
    send_frame(2, 9'h037, 8, 1, 1, 1'b0, 1, 2'b11);
    idle_bits(2, 1);
    check_frames("t3_odd");

    // Stop bit low followed by a 3-frame break, then a clean frame
    send_frame(0, 9'h03C, 8, 0, 0, 1'b0, 1, 2'b00);
    rx[0] = 1'b0;
    repeat (3 * 10 * BIT_CLK) @(negedge clk);
    idle_bits(0, 2);
    check_frames("t4_break");
    send_frame(0, 9'h096, 8, 0, 0, 1'b0, 1, 2'b11);
    idle_bits(0, 2);
    check_frames("t4_after");

    // 7 data bits, 2 stop bits
    send_frame(3, 9'h041, 7, 0, 0, 1'b0, 2, 2'b01);
    idle_bits(3, 1);
    send_frame(3, 9'h041, 7, 0, 0, 1'b0, 2, 2'b11);
    idle_bits(3, 1);
    check_frames("t5");

    // Reset after the third data bit of a frame
    drive_bit(0, 1'b0);
    drive_bit(0, 1'b1);
    drive_bit(0, 1'b0);
    drive_bit(0, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rx[0] = 1'b1;
    chk("t6_data", 32'(d0), 0);
    chk("t6_done", 32'(done[0]), 0);
    chk("t6_perr", 32'(pe[0]), 0);
    chk("t6_ferr", 32'(fe[0]), 0);
    chk("t6_busy", 32'(busy[0]), 0);
    idle_bits(0, 3);
    chk("t6_no_frame", cap_q.size(), 0);
    send_frame(0, 9'h0C3, 8, 0, 0, 1'b0, 1, 2'b11);
    idle_bits(0, 2);
    check_frames("t6");

    // Random frames on every format
    for (int k = 0; k < 4; k++) begin
      nb      = (k == 3) ? 7 : 8;
      nstop   = (k == 3) ? 2 : 1;
      par_en  = (k == 1 || k == 2);
      par_odd = (k == 2);
      for (int n = 0; n < 6; n++) begin
        rdata  = 9'($urandom);
        rpbit  = 1'($urandom_range(0, 1));
        rstops = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
        send_frame(k, rdata, nb, par_en, par_odd, rpbit, nstop, rstops);
        idle_bits(k, 1);
      end
      check_frames("rand");
    end

    chk("done_width", width_err, 0);
    chk("final_busy", 32'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
